// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button time-setting front end for the HH:MM:SS counter.
// Synchronises and debounces MODE/INC, walks HH -> MM -> SS -> commit, freezes
// the counter while editing and issues a one-cycle parallel load on commit.
module time_set_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    input  logic       i_pm,
    output logic       o_run_en,
    output logic       o_load,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic [1:0] o_field
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HH,
        ST_SET_MM,
        ST_SET_SS,
        ST_COMMIT
    } state_e;

    // ------------------------------------------------------------------
    // Button path: index 0 = MODE, index 1 = INC
    // ------------------------------------------------------------------
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    press_q, press_d;
    logic [CW-1:0] dcnt_q [2];
    logic [CW-1:0] dcnt_d [2];

    assign btn_raw = {i_btn_inc, i_btn_mode};

    // Stability counter per button; a press is flagged on the same edge the
    // debounced level rises, so releases never produce a pulse.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Synchroniser, debounce and press-pulse registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            dcnt_q[0] <= '0;
            dcnt_q[1] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            press_q   <= press_d;
            dcnt_q[0] <= dcnt_d[0];
            dcnt_q[1] <= dcnt_d[1];
        end
    end

    logic mode_p, inc_p;
    assign mode_p = press_q[0];
    assign inc_p  = press_q[1] & ~press_q[0];   // MODE wins a same-cycle tie

    // ------------------------------------------------------------------
    // BCD step helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] hh_step(input logic [7:0] h);
        logic [7:0] r;
        if (h == 8'h12)            r = 8'h01;
        else if (h[3:0] == 4'd9)   r = {h[7:4] + 4'd1, 4'd0};
        else                       r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] mm_step(input logic [7:0] m);
        logic [7:0] r;
        if (m == 8'h59)            r = 8'h00;
        else if (m[3:0] == 4'd9)   r = {m[7:4] + 4'd1, 4'd0};
        else                       r = {m[7:4], m[3:0] + 4'd1};
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Field-select FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic          pm_q, pm_d;
    logic          run_en_q, run_en_d;
    logic          load_q, load_d;
    logic [1:0]    field_q, field_d;

    // Next state, shadow edits, idle timeout and registered output decode
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        pm_d    = pm_q;

        unique case (state_q)
            ST_RUN: begin
                tcnt_d = '0;
                if (mode_p) begin
                    hh_d    = i_hh;
                    mm_d    = i_mm;
                    ss_d    = i_ss;
                    pm_d    = i_pm;
                    state_d = ST_SET_HH;
                end
            end
            ST_SET_HH, ST_SET_MM, ST_SET_SS: begin
                if (mode_p) begin
                    tcnt_d = '0;
                    unique case (state_q)
                        ST_SET_HH: state_d = ST_SET_MM;
                        ST_SET_MM: state_d = ST_SET_SS;
                        default:   state_d = ST_COMMIT;
                    endcase
                end else if (inc_p) begin
                    tcnt_d = '0;
                    unique case (state_q)
                        ST_SET_HH: begin
                            hh_d = hh_step(hh_q);
                            if (hh_q == 8'h11) pm_d = ~pm_q;
                        end
                        ST_SET_MM: mm_d = mm_step(mm_q);
                        default:   ss_d = 8'h00;
                    endcase
                end else if (tcnt_q == TMO_LAST) begin
                    tcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                tcnt_d  = '0;
                state_d = ST_RUN;
            end
        endcase

        run_en_d = (state_d == ST_RUN);
        load_d   = (state_d == ST_COMMIT);
        unique case (state_d)
            ST_SET_HH: field_d = 2'd1;
            ST_SET_MM: field_d = 2'd2;
            ST_SET_SS: field_d = 2'd3;
            default:   field_d = 2'd0;
        endcase
    end

    // State, timeout counter, shadow time and output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_RUN;
            tcnt_q   <= '0;
            hh_q     <= 8'h12;
            mm_q     <= 8'h00;
            ss_q     <= 8'h00;
            pm_q     <= 1'b0;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            field_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            hh_q     <= hh_d;
            mm_q     <= mm_d;
            ss_q     <= ss_d;
            pm_q     <= pm_d;
            run_en_q <= run_en_d;
            load_q   <= load_d;
            field_q  <= field_d;
        end
    end

    assign o_run_en = run_en_q;
    assign o_load   = load_q;
    assign o_field  = field_q;
    assign o_hh     = hh_q;
    assign o_mm     = mm_q;
    assign o_ss     = ss_q;
    assign o_pm     = pm_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed stimulus against a cycle-level behavioural model
// of the time-setting controller, plus hand-computed literal expectations.
module tb_time_set_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       b_mode = 1'b0, b_inc = 1'b0;
    logic [7:0] hh_in = 8'h10, mm_in = 8'h58, ss_in = 8'h37;
    logic       pm_in = 1'b0;
    logic       o_run_en, o_load, o_pm;
    logic [7:0] o_hh, o_mm, o_ss;
    logic [1:0] o_field;

    time_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_btn_mode(b_mode), .i_btn_inc(b_inc),
        .i_hh(hh_in), .i_mm(mm_in), .i_ss(ss_in), .i_pm(pm_in),
        .o_run_en(o_run_en), .o_load(o_load), .o_hh(o_hh), .o_mm(o_mm),
        .o_ss(o_ss), .o_pm(o_pm), .o_field(o_field)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit rst_at_edge = 1'b0;
    int loads = 0;
    logic [24:0] ld_vec = '0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // Time held as plain integers; a press is an event keyed by the edge on
    // which the controller must act on it.
    int m_h = 12, m_m = 0, m_s = 0;
    bit m_pm = 1'b0;
    int m_field = 0;       // 0 idle, 1 hours, 2 minutes, 3 seconds
    bit m_commit = 1'b0;
    int m_last = 0;        // edge of the last accepted press / edit entry
    bit mode_ev[int];
    bit inc_ev[int];

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_h = 12; m_m = 0; m_s = 0; m_pm = 1'b0;
        m_field = 0; m_commit = 1'b0;
    endtask

    task automatic model_step(input int e);
        bit m, n;
        m = mode_ev.exists(e);
        n = inc_ev.exists(e);
        if (m_commit) begin
            m_commit = 1'b0;
        end else if (m_field == 0) begin
            if (m) begin
                m_h = bcd2i(hh_in); m_m = bcd2i(mm_in); m_s = bcd2i(ss_in); m_pm = pm_in;
                m_field = 1; m_last = e;
            end
        end else if (m) begin
            m_last = e;
            if (m_field == 3) begin m_field = 0; m_commit = 1'b1; end
            else m_field++;
        end else if (n) begin
            m_last = e;
            if (m_field == 1) begin
                if (m_h == 11) m_pm = ~m_pm;
                m_h = (m_h == 12) ? 1 : m_h + 1;
            end else if (m_field == 2) m_m = (m_m + 1) % 60;
            else m_s = 0;
        end else if (e - m_last == TMO) begin
            m_field = 0;
        end
    endtask

    // Model advance and full-output comparison, once per cycle
    always @(negedge clk) begin
        logic [28:0] exp_v, act_v;
        if (!rst_n) model_reset();
        else if (rst_at_edge) model_step(cyc);
        exp_v = {(m_field == 0 && !m_commit), m_commit, 2'(m_field),
                 i2bcd(m_h), i2bcd(m_m), i2bcd(m_s), m_pm};
        act_v = {o_run_en, o_load, o_field, o_hh, o_mm, o_ss, o_pm};
        check("cycle", {3'b0, act_v}, {3'b0, exp_v});
        if (o_load === 1'b1) begin
            loads++;
            ld_vec = {o_hh, o_mm, o_ss, o_pm};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Raw high for hi sampled edges after edge k, then low for lo edges.
    task automatic press(input bit pm, input bit pi, input int hi, input int lo, output int k);
        @(posedge clk); #1;
        k = cyc;
        if (hi >= DEB + 2) begin
            if (pm) mode_ev[k + 3 + DEB] = 1'b1;
            if (pi) inc_ev[k + 3 + DEB] = 1'b1;
        end
        b_mode = pm; b_inc = pi;
        repeat (hi) @(posedge clk);
        #1;
        b_mode = 1'b0; b_inc = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: edge %0d reached no end, required completion", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int l0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_run_en", o_run_en, 1);
        check("rst_load", o_load, 0);
        check("rst_field", o_field, 0);
        check("rst_hh", o_hh, 32'h12);
        check("rst_mm", o_mm, 32'h00);
        check("rst_ss", o_ss, 32'h00);
        check("rst_pm", o_pm, 0);

        // INC in RUN does nothing
        press(1'b0, 1'b1, 6, 6, k);
        @(negedge clk);
        check("run_inc_hh", o_hh, 32'h12);

        // short glitch on MODE
        press(1'b1, 1'b0, 3, 10, k);
        @(negedge clk);
        check("glitch_field", o_field, 0);
        check("glitch_run_en", o_run_en, 1);

        // MODE held 40 cycles: one entry to SET_HH, then idle timeout
        l0 = loads;
        @(posedge clk); #1;
        k = cyc;
        mode_ev[k + 3 + DEB] = 1'b1;
        b_mode = 1'b1;
        at_edge(k + 6);
        check("held_before", o_field, 0);
        at_edge(k + 7);
        check("held_field", o_field, 1);
        check("held_run_en", o_run_en, 0);
        at_edge(k + 7 + 15);
        check("tmo_still_hh", o_field, 1);
        at_edge(k + 7 + 16);
        check("tmo_field", o_field, 0);
        check("tmo_run_en", o_run_en, 1);
        at_edge(k + 40);
        b_mode = 1'b0;
        repeat (10) @(negedge clk);
        check("tmo_no_load", loads - l0, 0);

        // full edit from 10:58:37 AM
        hh_in = 8'h10; mm_in = 8'h58; ss_in = 8'h37; pm_in = 1'b0;
        l0 = loads;
        press(1'b1, 1'b0, 6, 6, k);
        repeat (3) press(1'b0, 1'b1, 6, 6, k);
        press(1'b1, 1'b0, 6, 6, k);
        repeat (2) press(1'b0, 1'b1, 6, 6, k);
        press(1'b1, 1'b0, 6, 6, k);
        press(1'b0, 1'b1, 6, 6, k);
        press(1'b1, 1'b0, 6, 0, k);
        at_edge(k + 7);
        check("commit_load", o_load, 1);
        check("commit_run_en", o_run_en, 0);
        check("commit_hh", o_hh, 32'h01);
        check("commit_mm", o_mm, 32'h00);
        check("commit_ss", o_ss, 32'h00);
        check("commit_pm", o_pm, 1);
        at_edge(k + 8);
        check("after_load", o_load, 0);
        check("after_run_en", o_run_en, 1);
        repeat (10) @(negedge clk);
        check("load_count", loads - l0, 1);
        check("load_value", ld_vec, {8'h01, 8'h00, 8'h00, 1'b1});

        // simultaneous MODE+INC in SET_MM
        hh_in = 8'h03; mm_in = 8'h07; ss_in = 8'h21; pm_in = 1'b1;
        l0 = loads;
        press(1'b1, 1'b0, 6, 6, k);
        press(1'b1, 1'b0, 6, 6, k);
        press(1'b1, 1'b1, 6, 0, k);
        at_edge(k + 7);
        check("simul_field", o_field, 3);
        check("simul_mm", o_mm, 32'h07);
        repeat (30) @(negedge clk);
        check("simul_tmo_field", o_field, 0);
        check("simul_no_load", loads - l0, 0);

        // reset while editing minutes
        l0 = loads;
        press(1'b1, 1'b0, 6, 6, k);
        press(1'b1, 1'b0, 6, 2, k);
        @(negedge clk);
        check("pre_rst_field", o_field, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_run_en", o_run_en, 1);
        check("mid_rst_field", o_field, 0);
        check("mid_rst_load", o_load, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_hh", o_hh, 32'h12);
        check("post_rst_no_load", loads - l0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
